dtree_channel_scheduler: RTL and testbench

//  Shares one dtree classifier core between CHANNELS spike sources. Round-robin grants one channel,

---
 rtl/dtree_channel_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_dtree_channel_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_channel_scheduler.sv
// Round-robin scheduler sharing one dtree classifier core between CHANNELS
// spike sources. One spike in flight: arbitrate, stream FEATURES samples,
// wait for level/path (or time out), then hold the tagged result until taken.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   ch_valid/ready    per-channel sample handshake, ch_sample packed by channel
//   tree_in_valid/... sample stream to the core, tree_ch selects its node set
//   tree_out_valid    one-cycle result pulse with tree_level / tree_path
//   res_*             tagged result, held until res_valid & res_ready
//   busy              scheduler not idle
module dtree_channel_scheduler #(
    parameter int CHANNELS = 4,
    parameter int IN_WIDTH = 10,
    parameter int FEATURES = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            ch_valid,
    output logic [CHANNELS-1:0]            ch_ready,
    input  logic [CHANNELS*IN_WIDTH-1:0]   ch_sample,
    output logic                           tree_in_valid,
    input  logic                           tree_ready,
    output logic [IN_WIDTH-1:0]            tree_sample,
    output logic [$clog2(CHANNELS)-1:0]    tree_ch,
    input  logic                           tree_out_valid,
    input  logic [$clog2(FEATURES)-1:0]    tree_level,
    input  logic [$clog2(FEATURES)-1:0]    tree_path,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [$clog2(CHANNELS)-1:0]    res_ch,
    output logic [$clog2(FEATURES)-1:0]    res_level,
    output logic [$clog2(FEATURES)-1:0]    res_path,
    output logic                           res_timeout,
    output logic                           busy
);

    localparam int CW = $clog2(CHANNELS);
    localparam int LW = $clog2(FEATURES);
    localparam int NW = $clog2(FEATURES + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   rr_q, rr_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [LW-1:0]   pth_q, pth_d;
    logic            to_q, to_d;

    logic [CW-1:0]       pick;
    logic                found;
    logic [CW:0]         cand;
    logic [IN_WIDTH-1:0] sel_sample;
    logic                sel_valid;
    logic                xfer;

    // First requester at or after rr_q, wrapping modulo CHANNELS.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = {1'b0, rr_q} + (CW+1)'(i);
            if (cand >= (CW+1)'(CHANNELS)) begin
                cand = cand - (CW+1)'(CHANNELS);
            end
            if (!found && ch_valid[cand[CW-1:0]]) begin
                found = 1'b1;
                pick  = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        sel_sample = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q == CW'(i)) begin
                sel_sample = ch_sample[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    assign sel_valid = ch_valid[grant_q];
    assign xfer      = (state_q == S_FEED) && sel_valid && tree_ready;

    // Samples pass straight through to the core; nothing is buffered here.
    always_comb begin
        ch_ready      = '0;
        tree_in_valid = 1'b0;
        tree_sample   = '0;
        if (state_q == S_FEED) begin
            tree_in_valid     = sel_valid;
            tree_sample       = sel_sample;
            ch_ready[grant_q] = tree_ready;
        end
    end

    assign tree_ch     = (state_q == S_IDLE) ? '0 : grant_q;
    assign res_valid   = (state_q == S_EMIT);
    assign res_ch      = res_valid ? grant_q : '0;
    assign res_level   = lvl_q;
    assign res_path    = pth_q;
    assign res_timeout = to_q;
    assign busy        = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        lvl_d   = lvl_q;
        pth_d   = pth_q;
        to_d    = to_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    rr_d    = (pick == CW'(CHANNELS - 1)) ? '0 : pick + CW'(1);
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (xfer) begin
                    if (cnt_q == NW'(FEATURES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + NW'(1);
                    end
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A pulse on the last allowed cycle still counts as a result.
                if (tree_out_valid) begin
                    lvl_d   = tree_level;
                    pth_d   = tree_path;
                    to_d    = 1'b0;
                    timer_d = '0;
                    state_d = S_EMIT;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    lvl_d   = '0;
                    pth_d   = '0;
                    to_d    = 1'b1;
                    timer_d = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            lvl_q   <= '0;
            pth_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            lvl_q   <= lvl_d;
            pth_q   <= pth_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_dtree_channel_scheduler.sv
// Bench for dtree_channel_scheduler: directed scenarios plus a randomized
// run against a transaction-level model of sources, core and arbitration.
module tb_dtree_channel_scheduler;

    localparam int CH = 4;
    localparam int W  = 10;
    localparam int TO = 16;
    localparam int NS = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ch_valid = '0;
    logic [3:0]  ch_ready;
    logic [39:0] ch_sample = '0;
    logic        tree_in_valid;
    logic        tree_ready = 1'b0;
    logic [9:0]  tree_sample;
    logic [1:0]  tree_ch;
    logic        tree_out_valid = 1'b0;
    logic [1:0]  tree_level = '0;
    logic [1:0]  tree_path = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_ch;
    logic [1:0]  res_level;
    logic [1:0]  res_path;
    logic        res_timeout;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    dtree_channel_scheduler #(
        .CHANNELS(4), .IN_WIDTH(10), .FEATURES(3), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(rst_n),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_sample(ch_sample),
        .tree_in_valid(tree_in_valid), .tree_ready(tree_ready),
        .tree_sample(tree_sample), .tree_ch(tree_ch),
        .tree_out_valid(tree_out_valid), .tree_level(tree_level),
        .tree_path(tree_path),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_level(res_level), .res_path(res_path),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_smp(input int c, input logic [9:0] v);
        ch_sample[c*W +: W] = v;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({ch_ready, tree_in_valid, tree_sample, tree_ch,
                      res_valid, res_ch, res_level, res_path,
                      res_timeout, busy}), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("rst_outs");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic feed_spike(input int g, input logic [3:0] mask,
                              input logic [9:0] s0, input logic [9:0] s1,
                              input logic [9:0] s2);
        logic [9:0] s[3];
        s = '{s0, s1, s2};
        ch_valid   = mask;
        tree_ready = 1'b1;
        for (int c = 0; c < CH; c++) set_smp(c, 10'($urandom));
        @(negedge clk);
        chk("arb_busy", 32'(busy), 32'd0);
        chk("arb_ch", 32'(tree_ch), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_smp(g, s[k]);
            @(negedge clk);
            chk("feed_ch", 32'(tree_ch), 32'(g));
            chk("feed_smp", 32'(tree_sample), 32'(s[k]));
            chk("feed_rdy", 32'(ch_ready), 32'(1 << g));
            tick();
        end
    endtask

    task automatic finish_spike(input int g, input int lat, input int lv,
                                input int pa, input int stall);
        logic [1:0] el;
        logic [1:0] ep;
        logic       eto;
        if (lat <= TO) begin
            for (int w = 1; w < lat; w++) begin
                @(negedge clk);
                chk("wait_rv", 32'(res_valid), 32'd0);
                tick();
            end
            tree_out_valid = 1'b1;
            tree_level     = 2'(lv);
            tree_path      = 2'(pa);
            @(negedge clk);
            chk("pulse_rv", 32'(res_valid), 32'd0);
            tick();
            tree_out_valid = 1'b0;
            tree_level     = 2'(lv + 1);
            tree_path      = 2'(pa + 2);
            el  = 2'(lv);
            ep  = 2'(pa);
            eto = 1'b0;
        end else begin
            for (int w = 1; w <= TO; w++) begin
                @(negedge clk);
                chk("wait_rv", 32'(res_valid), 32'd0);
                tick();
            end
            el  = 2'd0;
            ep  = 2'd0;
            eto = 1'b1;
        end
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) res_ready = 1'b1;
            @(negedge clk);
            chk("emit_rv", 32'(res_valid), 32'd1);
            chk("emit_ch", 32'(res_ch), 32'(g));
            chk("emit_lvl", 32'(res_level), 32'(el));
            chk("emit_pth", 32'(res_path), 32'(ep));
            chk("emit_to", 32'(res_timeout), 32'(eto));
            chk("emit_rdy", 32'(ch_ready), 32'd0);
            chk("emit_busy", 32'(busy), 32'd1);
            tick();
        end
        res_ready = 1'b0;
    endtask

    task automatic spike(input int g, input logic [3:0] mask, input int lat,
                         input int lv, input int pa, input int stall);
        feed_spike(g, mask, 10'($urandom), 10'($urandom), 10'($urandom));
        finish_spike(g, lat, lv, pa, stall);
    endtask

    logic [9:0] mem[4][NS];
    int         rd[4];
    int         mptr, eg, nx, wc, lat_r, cyc, idx;
    bit         gv, waiting, pn, pa_r, idle0, feed, done, found;
    logic [1:0] el_r, ep_r;
    bit         eto_r;
    bit         vp[7];
    bit         rp[7];
    logic [9:0] gs[3];

    initial begin
        #2;
        chk_zero("rst_outs");
        tick();
        tick();
        rst_n = 1'b1;

        // 1: single channel, known samples and result
        feed_spike(2, 4'b0100, 10'd5, 10'h3FD, 10'd7);
        ch_valid = '0;
        finish_spike(2, 1, 1, 2, 0);

        // 2: all requesting, strict rotation from channel 0
        apply_reset();
        spike(0, 4'b1111, 2, 0, 1, 0);
        spike(1, 4'b1111, 1, 1, 0, 0);
        spike(2, 4'b1111, 3, 2, 2, 0);
        spike(3, 4'b1111, 4, 1, 1, 0);
        spike(0, 4'b1111, 1, 2, 0, 0);

        // 4: result back-pressure, no new grant while holding
        spike(1, 4'b1111, 3, 2, 1, 5);

        // 3: stalls from both sides mid-spike
        vp = '{1, 1, 0, 1, 1, 1, 1};
        rp = '{1, 0, 1, 0, 1, 0, 1};
        gs = '{10'd100, 10'd200, 10'd300};
        idx = 0;
        ch_valid   = 4'b0001;
        tree_ready = 1'b1;
        set_smp(0, gs[0]);
        @(negedge clk);
        chk("gap_arb", 32'(busy), 32'd0);
        tick();
        for (int c = 0; c < 7; c++) begin
            ch_valid[0] = vp[c];
            tree_ready  = rp[c];
            set_smp(0, gs[idx < 3 ? idx : 2]);
            @(negedge clk);
            chk("gap_iv", 32'(tree_in_valid), 32'(vp[c]));
            chk("gap_rdy", 32'(ch_ready), 32'(rp[c]));
            if (vp[c] && rp[c]) begin
                chk("gap_smp", 32'(tree_sample), 32'(gs[idx]));
                idx++;
            end
            tick();
        end
        ch_valid   = 4'b0001;
        tree_ready = 1'b1;
        @(negedge clk);
        chk("gap_noxtra", 32'(tree_in_valid), 32'd0);
        tick();
        ch_valid = '0;
        finish_spike(0, 2, 1, 1, 0);

        // 5: timeout, then a pulse on the last WAIT cycle
        spike(3, 4'b1000, 20, 0, 0, 0);
        spike(3, 4'b1000, 16, 2, 1, 0);

        // 6: reset mid-spike
        ch_valid   = 4'b0010;
        tree_ready = 1'b1;
        @(negedge clk);
        chk("rm_arb", 32'(busy), 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_smp(1, 10'(k + 40));
            @(negedge clk);
            chk("rm_smp", 32'(tree_sample), 32'(k + 40));
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk_zero("rm_outs");
        tick();
        tick();
        rst_n = 1'b1;
        spike(1, 4'b1010, 3, 1, 2, 1);

        // randomized run against the transaction model
        apply_reset();
        for (int i = 0; i < CH; i++) begin
            rd[i] = 0;
            for (int k = 0; k < NS; k++) mem[i][k] = 10'($urandom);
        end
        mptr = 0; eg = 0; nx = 0; wc = 0; lat_r = 0; cyc = 0;
        gv = 0; waiting = 0; pn = 0; pa_r = 0;
        el_r = '0; ep_r = '0; eto_r = 0;
        done = 0;
        while (cyc < 4000 && !done) begin
            if (pn) begin
                pa_r = 1;
                pn   = 0;
            end
            for (int i = 0; i < CH; i++) begin
                ch_valid[i] = (rd[i] < NS) && ($urandom_range(0, 3) != 0);
                set_smp(i, rd[i] < NS ? mem[i][rd[i]] : 10'($urandom));
            end
            tree_ready     = ($urandom_range(0, 3) != 0);
            res_ready      = ($urandom_range(0, 2) != 0);
            tree_out_valid = 1'b0;
            tree_level     = 2'($urandom_range(0, 2));
            tree_path      = 2'($urandom_range(0, 2));
            if (waiting) begin
                wc++;
                if (wc == lat_r) begin
                    tree_out_valid = 1'b1;
                    el_r = tree_level;
                    ep_r = tree_path;
                    eto_r = 0;
                    pn = 1;
                    waiting = 0;
                end else if (wc == TO) begin
                    el_r = '0;
                    ep_r = '0;
                    eto_r = 1;
                    pn = 1;
                    waiting = 0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                tree_out_valid = 1'b1;
            end
            @(negedge clk);
            idle0 = !gv;
            feed  = gv && (nx < 3);
            chk("rnd_busy", 32'(busy), 32'(gv));
            chk("rnd_rdy", 32'(ch_ready),
                (feed && tree_ready) ? 32'(1 << eg) : 32'd0);
            chk("rnd_iv", 32'(tree_in_valid), 32'(feed && ch_valid[eg]));
            if (feed && ch_valid[eg] && tree_ready) begin
                chk("rnd_smp", 32'(tree_sample), 32'(mem[eg][rd[eg]]));
                chk("rnd_ch", 32'(tree_ch), 32'(eg));
                rd[eg]++;
                nx++;
                if (nx == 3) begin
                    waiting = 1;
                    wc = 0;
                    lat_r = $urandom_range(1, 18);
                end
            end
            if (pa_r) begin
                chk("rnd_rv", 32'(res_valid), 32'd1);
                chk("rnd_rch", 32'(res_ch), 32'(eg));
                chk("rnd_lvl", 32'(res_level), 32'(el_r));
                chk("rnd_pth", 32'(res_path), 32'(ep_r));
                chk("rnd_to", 32'(res_timeout), 32'(eto_r));
                if (res_ready) begin
                    pa_r = 0;
                    gv = 0;
                end
            end else begin
                chk("rnd_rv", 32'(res_valid), 32'd0);
            end
            if (idle0 && (|ch_valid)) begin
                found = 0;
                for (int k = 0; k < CH; k++) begin
                    if (!found && ch_valid[(mptr + k) % CH]) begin
                        found = 1;
                        eg = (mptr + k) % CH;
                    end
                end
                mptr = (eg + 1) % CH;
                gv = 1;
                nx = 0;
            end
            tick();
            cyc++;
            done = !gv;
            for (int i = 0; i < CH; i++) if (rd[i] < NS) done = 0;
        end
        chk("rnd_done", 32'(done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
